// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the frame-granular AXI-Stream arbiter.
package axis_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

  // Upper bound on NUM_PORTS accepted by rr_pick.
  localparam int unsigned ARB_MAX_PORTS = 32;

  function automatic int unsigned arb_idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ARB_DEFAULT_IDX_W = arb_idx_w(4);

  // First requester at or after ptr, wrapping modulo n.
  function automatic int unsigned rr_pick(logic [ARB_MAX_PORTS-1:0] req,
                                          int unsigned ptr, int unsigned n);
    int unsigned pick;
    int unsigned idx;
    logic        found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (!found && req[idx[4:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered AXI-Stream slice; ready is a registered not-full flag.
module axis_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_fire;

  assign in_ready_o = ~skid_valid_q;
  assign in_fire    = in_valid_i & ~skid_valid_q;

  // The skid entry only fills while the output register is stalled, so it
  // always holds the older of any two buffered beats' successor.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_q || out_ready_i) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) out_data_d = in_data_i;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_data_q   <= out_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/axis_frame_arbiter.sv
// N:1 round-robin AXI-Stream arbiter that locks the grant for a whole frame
// (released after tlast) and registers the output through a 2-entry skid buffer.
module axis_frame_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned ID_WIDTH   = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                s_tvalid,
  output logic [NUM_PORTS-1:0]                s_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     s_tdata,
  input  logic [NUM_PORTS-1:0]                s_tlast,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]     s_tuser,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   s_tkeep,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   s_tstrb,
  input  logic [NUM_PORTS*DEST_WIDTH-1:0]     s_tdest,
  input  logic [NUM_PORTS*ID_WIDTH-1:0]       s_tid,
  output logic                                m_tvalid,
  input  logic                                m_tready,
  output logic [DATA_WIDTH-1:0]               m_tdata,
  output logic                                m_tlast,
  output logic [USER_WIDTH-1:0]               m_tuser,
  output logic [DATA_WIDTH/8-1:0]             m_tkeep,
  output logic [DATA_WIDTH/8-1:0]             m_tstrb,
  output logic [DEST_WIDTH-1:0]               m_tdest,
  output logic [ID_WIDTH-1:0]                 m_tid,
  output logic                                grant_valid,
  output logic [arb_idx_w(NUM_PORTS)-1:0]     grant_idx
);

  localparam int unsigned IDX_W = arb_idx_w(NUM_PORTS);
  localparam int unsigned KW    = DATA_WIDTH / 8;
  localparam int unsigned BW    = 1 + USER_WIDTH + 2 * KW + DEST_WIDTH + ID_WIDTH + DATA_WIDTH;

  arb_state_e         state_q;
  logic               grant_valid_q;
  logic [IDX_W-1:0]   grant_idx_q;
  logic [IDX_W-1:0]   rr_ptr_q;

  logic               sel_valid;
  logic [BW-1:0]      sel_beat;
  logic               sel_last;
  logic               in_valid;
  logic               skid_ready;
  logic               accept;
  logic [BW-1:0]      out_beat;
  logic [ARB_MAX_PORTS-1:0] req_ext;

  assign req_ext = ARB_MAX_PORTS'(s_tvalid);

  // One-hot mux of the granted port into a single {last,user,keep,strb,dest,id,data} bundle.
  always_comb begin
    sel_valid = 1'b0;
    sel_beat  = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (grant_idx_q == IDX_W'(p)) begin
        sel_valid = s_tvalid[p];
        sel_beat  = {s_tlast[p],
                     s_tuser[p*USER_WIDTH +: USER_WIDTH],
                     s_tkeep[p*KW +: KW],
                     s_tstrb[p*KW +: KW],
                     s_tdest[p*DEST_WIDTH +: DEST_WIDTH],
                     s_tid[p*ID_WIDTH +: ID_WIDTH],
                     s_tdata[p*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  assign sel_last = sel_beat[BW-1];
  assign in_valid = (state_q == ARB_LOCK) & sel_valid;
  assign accept   = in_valid & skid_ready;

  always_comb begin
    s_tready = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (state_q == ARB_LOCK && grant_idx_q == IDX_W'(p)) s_tready[p] = skid_ready;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      rr_ptr_q      <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|s_tvalid) begin
            state_q       <= ARB_LOCK;
            grant_valid_q <= 1'b1;
            grant_idx_q   <= IDX_W'(rr_pick(req_ext, 32'(rr_ptr_q), NUM_PORTS));
          end
        end
        ARB_LOCK: begin
          if (accept && sel_last) begin
            state_q       <= ARB_IDLE;
            grant_valid_q <= 1'b0;
            rr_ptr_q      <= (grant_idx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx_q + 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  axis_skid_buffer #(
    .WIDTH(BW)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (skid_ready),
    .in_data_i   (sel_beat),
    .out_valid_o (m_tvalid),
    .out_ready_i (m_tready),
    .out_data_o  (out_beat)
  );

  assign {m_tlast, m_tuser, m_tkeep, m_tstrb, m_tdest, m_tid, m_tdata} = out_beat;
  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Bench for axis_frame_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_axis_frame_arbiter;

  localparam int NP = 4, DW = 8, UW = 1, KW = 1, DSW = 1, IW = 1;

  typedef struct packed {
    logic           last;
    logic [UW-1:0]  user;
    logic [KW-1:0]  keep;
    logic [KW-1:0]  strb;
    logic [DSW-1:0] dest;
    logic [IW-1:0]  id;
    logic [DW-1:0]  data;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NP-1:0]     s_tvalid, s_tready, s_tlast;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP*UW-1:0]  s_tuser;
  logic [NP*KW-1:0]  s_tkeep, s_tstrb;
  logic [NP*DSW-1:0] s_tdest;
  logic [NP*IW-1:0]  s_tid;
  logic              m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]     m_tdata;
  logic [UW-1:0]     m_tuser;
  logic [KW-1:0]     m_tkeep, m_tstrb;
  logic [DSW-1:0]    m_tdest;
  logic [IW-1:0]     m_tid;
  logic              grant_valid;
  logic [1:0]        grant_idx;

  axis_frame_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .USER_WIDTH(UW),
                       .DEST_WIDTH(DSW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .s_tuser(s_tuser), .s_tkeep(s_tkeep), .s_tstrb(s_tstrb), .s_tdest(s_tdest), .s_tid(s_tid),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .m_tkeep(m_tkeep), .m_tstrb(m_tstrb), .m_tdest(m_tdest), .m_tid(m_tid),
    .grant_valid(grant_valid), .grant_idx(grant_idx));

  // Single-port instance
  logic          s1_tvalid, s1_tready, m1_tvalid, m1_tlast, grant_valid1;
  logic [DW-1:0] s1_tdata, m1_tdata;
  logic [UW-1:0] m1_tuser;
  logic [KW-1:0] m1_tkeep, m1_tstrb;
  logic [DSW-1:0] m1_tdest;
  logic [IW-1:0] m1_tid;
  logic [0:0]    grant_idx1;

  axis_frame_arbiter #(.NUM_PORTS(1)) dut1 (
    .clk(clk), .rst(rst),
    .s_tvalid(s1_tvalid), .s_tready(s1_tready), .s_tdata(s1_tdata), .s_tlast(1'b1),
    .s_tuser(1'b1), .s_tkeep(1'b1), .s_tstrb(1'b1), .s_tdest(1'b0), .s_tid(1'b0),
    .m_tvalid(m1_tvalid), .m_tready(1'b1), .m_tdata(m1_tdata), .m_tlast(m1_tlast),
    .m_tuser(m1_tuser), .m_tkeep(m1_tkeep), .m_tstrb(m1_tstrb), .m_tdest(m1_tdest), .m_tid(m1_tid),
    .grant_valid(grant_valid1), .grant_idx(grant_idx1));

  int unsigned n_checks = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Sources, reference model and logs
  beat_t       srcq[NP][$];
  bit          force_off[NP];
  int unsigned vld_pct = 100, rdy_pct = 100;
  bit          rdy_pat[$];
  logic [NP-1:0] drv_valid;
  bit          drv_mready;
  beat_t       bufq[$];
  bit          m_locked;
  int          m_gidx, m_ptr;
  beat_t       out_log[$];
  int          grant_log[$];
  bit          prev_gv;

  function automatic logic [NP-1:0] exp_ready();
    logic [NP-1:0] r = '0;
    if (m_locked && bufq.size() < 2) r[m_gidx] = 1'b1;
    return r;
  endfunction

  function automatic bit model_idle();
    bit idle = !m_locked && bufq.size() == 0;
    for (int p = 0; p < NP; p++) if (srcq[p].size() != 0) idle = 0;
    return idle;
  endfunction

  task automatic model_reset();
    bufq.delete();
    m_locked = 0; m_gidx = 0; m_ptr = 0; prev_gv = 0;
  endtask

  task automatic add_frame(input int p, input int len, input logic [7:0] first, input bit seq);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = seq ? first + 8'(i) : 8'($urandom);
      b.last = (i == len - 1);
      b.user = (i == 0);
      b.keep = 1'($urandom); b.strb = 1'($urandom);
      b.dest = 1'($urandom); b.id = 1'($urandom);
      srcq[p].push_back(b);
    end
  endtask

  task automatic drive();
    beat_t b;
    for (int p = 0; p < NP; p++) begin
      b = (srcq[p].size() > 0) ? srcq[p][0] : '0;
      drv_valid[p] = srcq[p].size() > 0 && !force_off[p] && ($urandom_range(99) < vld_pct);
      s_tdata[p*DW +: DW] = b.data;  s_tlast[p] = b.last;
      s_tuser[p*UW +: UW] = b.user;  s_tkeep[p*KW +: KW] = b.keep;
      s_tstrb[p*KW +: KW] = b.strb;  s_tdest[p*DSW +: DSW] = b.dest;
      s_tid[p*IW +: IW] = b.id;
    end
    s_tvalid = drv_valid;
    drv_mready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : ($urandom_range(99) < rdy_pct);
    m_tready = drv_mready;
  endtask

  task automatic model_update();
    beat_t b = '0;
    bit pop = bufq.size() > 0 && drv_mready;
    bit acc = m_locked && drv_valid[m_gidx] && bufq.size() < 2;
    if (pop) void'(bufq.pop_front());
    if (acc) begin b = srcq[m_gidx].pop_front(); bufq.push_back(b); end
    if (!m_locked) begin
      for (int k = NP - 1; k >= 0; k--)
        if (drv_valid[(m_ptr + k) % NP]) begin m_gidx = (m_ptr + k) % NP; m_locked = 1; end
    end else if (acc && b.last) begin
      m_locked = 0;
      m_ptr = (m_gidx + 1) % NP;
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step();
    beat_t ob;
    ob = {m_tlast, m_tuser, m_tkeep, m_tstrb, m_tdest, m_tid, m_tdata};
    chk("m_tvalid", m_tvalid, bufq.size() > 0);
    if (bufq.size() > 0) chk("m_beat", ob, bufq[0]);
    chk("s_tready", s_tready, exp_ready());
    chk("grant_valid", grant_valid, m_locked);
    if (m_locked) chk("grant_idx", grant_idx, m_gidx);
    if (grant_valid && !prev_gv) grant_log.push_back(int'(grant_idx));
    prev_gv = grant_valid;
    drive();
    if (m_tvalid && m_tready) out_log.push_back(ob);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    bit idle = 0;
    for (int i = 0; i < budget && !idle; i++) begin
      step();
      idle = model_idle();
    end
    chk(tag, idle, 1'b1);
  endtask

  task automatic check_grants(input string tag, input int exp[$]);
    chk({tag, "_count"}, grant_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < grant_log.size(); i++)
      chk($sformatf("%s_%0d", tag, i), grant_log[i], exp[i]);
  endtask

  initial begin
    beat_t frame[$];
    int    gen_beats;
    bit    saw_drop;
    int    nout;
    logic [7:0] exp1;
    bit    acc1;

    rst = 1'b1;
    m_tready = 1'b1;
    s1_tvalid = 1'b0; s1_tdata = '0;
    for (int p = 0; p < NP; p++) force_off[p] = 0;
    drive();
    repeat (3) @(negedge clk);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_m_tdata", m_tdata, 8'h00);
    chk("rst_s_tready", s_tready, 4'h0);
    chk("rst_grant_valid", grant_valid, 1'b0);
    chk("rst_grant_idx", grant_idx, 2'd0);
    chk("rst_n1_m_tvalid", m1_tvalid, 1'b0);
    rst = 1'b0;
    model_reset();

    // Port 2 sends A1,A2,A3
    add_frame(2, 3, 8'hA1, 1);
    out_log.delete(); grant_log.delete();
    run_until_idle("t1_idle", 40);
    chk("t1_beats", out_log.size(), 3);
    for (int i = 0; i < 3 && i < out_log.size(); i++) begin
      chk($sformatf("t1_data%0d", i), out_log[i].data, 8'hA1 + 8'(i));
      chk($sformatf("t1_last%0d", i), out_log[i].last, i == 2);
    end
    check_grants("t1_grant", '{2});

    // All ports with two 2-beat frames each; pointer sits at 3 after port 2's frame
    for (int r = 0; r < 2; r++) for (int p = 0; p < NP; p++) add_frame(p, 2, 8'(16 * p + 4 * r), 1);
    grant_log.delete();
    run_until_idle("t2_idle", 100);
    check_grants("t2_grant", '{3, 0, 1, 2, 3, 0, 1, 2});

    // Port 1, 5 beats, downstream ready 1,0,0,1,0,0,...
    add_frame(1, 5, 8'h50, 0);
    frame = srcq[1];
    for (int i = 0; i < 30; i++) rdy_pat.push_back(i % 3 == 0);
    out_log.delete();
    saw_drop = 0;
    for (int i = 0; i < 40 && !model_idle(); i++) begin
      if (grant_valid && !s_tready[1]) saw_drop = 1;
      step();
    end
    rdy_pat.delete();
    chk("t3_idle", model_idle(), 1'b1);
    chk("t3_ready_dropped", saw_drop, 1'b1);
    chk("t3_beats", out_log.size(), 5);
    for (int i = 0; i < 5 && i < out_log.size(); i++)
      chk($sformatf("t3_beat%0d", i), out_log[i], frame[i]);

    // Port 0 stalls mid-frame while port 3 waits
    add_frame(0, 4, 8'h00, 0);
    grant_log.delete();
    for (int i = 0; i < 10 && srcq[0].size() == 4; i++) step();
    add_frame(3, 2, 8'h30, 1);
    force_off[0] = 1;
    repeat (4) begin
      chk("t4_p3_ready", s_tready[3], 1'b0);
      step();
    end
    force_off[0] = 0;
    run_until_idle("t4_idle", 40);
    check_grants("t4_grant", '{0, 3});

    // Asynchronous reset with two beats buffered
    rdy_pct = 0;
    add_frame(1, 5, 8'h70, 1);
    add_frame(3, 2, 8'h90, 1);
    for (int i = 0; i < 12 && bufq.size() < 2; i++) step();
    chk("t5_buffered", bufq.size(), 2);
    #2 rst = 1'b1;
    #1;
    chk("t5_m_tvalid", m_tvalid, 1'b0);
    chk("t5_s_tready", s_tready, 4'h0);
    chk("t5_grant_valid", grant_valid, 1'b0);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    rdy_pct = 100;
    grant_log.delete();
    run_until_idle("t5_idle", 60);
    check_grants("t5_grant", '{1, 3});

    // Randomized traffic
    vld_pct = 80; rdy_pct = 70;
    gen_beats = 0;
    out_log.delete();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) begin
        int p = int'($urandom_range(NP - 1));
        int len = int'($urandom_range(1, 5));
        if (srcq[p].size() < 8) begin add_frame(p, len, 8'h00, 0); gen_beats += len; end
      end
      step();
    end
    vld_pct = 100; rdy_pct = 100;
    run_until_idle("rand_idle", 300);
    chk("rand_beats", out_log.size(), gen_beats);

    // Single-port instance: back-to-back 1-beat frames
    s1_tvalid = 1'b1;
    nout = 0; exp1 = 8'h00;
    for (int i = 0; i < 40; i++) begin
      if (m1_tvalid) begin chk("n1_data", m1_tdata, exp1); exp1++; nout++; end
      if (grant_valid1) chk("n1_grant", grant_idx1, 1'b0);
      acc1 = s1_tready;
      @(posedge clk);
      @(negedge clk);
      if (acc1) s1_tdata = s1_tdata + 8'd1;
    end
    // Accepts land on every second edge starting with the second, so 19 of 40 samples carry a beat.
    chk("n1_rate", nout, 19);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
